// File: rtl/imem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS).
// One transaction in flight; LS wins by default, a starvation counter forces IF through.
module imem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    input  logic                    i_if_flush,
    output logic                    o_if_gnt,
    output logic                    o_if_rvalid,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    input  logic                    i_ls_req,
    input  logic                    i_ls_we,
    input  logic [ADDR_WIDTH-1:0]   i_ls_addr,
    input  logic [DATA_WIDTH-1:0]   i_ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_ls_be,
    output logic                    o_ls_gnt,
    output logic                    o_ls_rvalid,
    output logic [DATA_WIDTH-1:0]   o_ls_rdata,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    input  logic                    i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

    localparam int         BW    = DATA_WIDTH / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_starve_cnt;
    logic                  r_drop;
    logic                  r_if_rvalid;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic                  r_ls_rvalid;
    logic [DATA_WIDTH-1:0] r_ls_rdata;
    logic                  r_ls_we;
    logic                  w_if_elig;
    logic                  w_if_gnt;
    logic                  w_ls_gnt;

    assign w_if_elig = i_if_req & ~i_if_flush;

    always_comb begin
        w_if_gnt     = 1'b0;
        w_ls_gnt     = 1'b0;
        w_next_state = r_state;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_be     = '0;
        case (r_state)
            IDLE: begin
                if ((r_starve_cnt == LIMIT) && w_if_elig) begin
                    w_if_gnt = 1'b1;
                end else if (i_ls_req) begin
                    w_ls_gnt = 1'b1;
                end else if (w_if_elig) begin
                    w_if_gnt = 1'b1;
                end
                if (w_if_gnt) begin
                    w_next_state = WAIT_IF;
                    o_mem_addr   = i_if_addr;
                    o_mem_be     = {BW{1'b1}};
                end else if (w_ls_gnt) begin
                    w_next_state = WAIT_LS;
                    o_mem_we     = i_ls_we;
                    o_mem_addr   = i_ls_addr;
                    o_mem_wdata  = i_ls_wdata;
                    o_mem_be     = i_ls_be;
                end
            end
            WAIT_IF: if (i_mem_rvalid) w_next_state = IDLE;
            WAIT_LS: if (i_mem_rvalid) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign o_if_gnt  = w_if_gnt;
    assign o_ls_gnt  = w_ls_gnt;
    assign o_mem_req = w_if_gnt | w_ls_gnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_drop       <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_ls_rvalid  <= 1'b0;
            r_ls_rdata   <= '0;
            r_ls_we      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_if_gnt || !i_if_req) begin
                        r_starve_cnt <= '0;
                    end else if (w_ls_gnt && w_if_elig && (r_starve_cnt < LIMIT)) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                    if (w_ls_gnt) r_ls_we <= i_ls_we;
                end
                WAIT_IF: begin
                    if (i_if_flush) r_drop <= 1'b1;
                    // A flush in the response cycle itself must also discard it.
                    if (i_mem_rvalid) begin
                        r_drop <= 1'b0;
                        if (!(r_drop || i_if_flush)) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= i_mem_rdata;
                        end
                    end
                end
                WAIT_LS: begin
                    if (i_mem_rvalid) begin
                        r_ls_rvalid <= 1'b1;
                        r_ls_rdata  <= r_ls_we ? '0 : i_mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_if_rvalid = r_if_rvalid;
    assign o_if_rdata  = r_if_rdata;
    assign o_ls_rvalid = r_ls_rvalid;
    assign o_ls_rdata  = r_ls_rdata;

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Arbitrates one single-ported instruction/data memory between the fetch stage (IF) and the load/store unit (LS).
- Sits between the fetch stage, the LSU and the unified memory.
- One outstanding transaction at a time. LS has default priority. An anti-starvation counter protects IF.
- Supports fetch flush on PC redirect (branch/jump): a flushed in-flight IF response is discarded.

Parameters:
- ADDR_WIDTH, 32, byte address width of both requesters and the memory.
- DATA_WIDTH, 32, data/instruction width.
- STARVE_LIMIT, 4, number of consecutive IF losses after which IF is forced to win the next arbitration (range 1..15).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_if_req  in  1  IF read request; held with address until granted
- i_if_addr  in  ADDR_WIDTH  IF fetch address
- i_if_flush  in  1  PC redirect; cancels IF grant this cycle and any in-flight IF response
- o_if_gnt  out  1  IF request accepted this cycle
- o_if_rvalid  out  1  IF instruction valid (1-cycle pulse)
- o_if_rdata  out  DATA_WIDTH  fetched instruction
- i_ls_req  in  1  LS request; held with all fields until granted
- i_ls_we  in  1  1 = write, 0 = read
- i_ls_addr  in  ADDR_WIDTH  LS address
- i_ls_wdata  in  DATA_WIDTH  LS write data
- i_ls_be  in  DATA_WIDTH/8  LS byte enables
- o_ls_gnt  out  1  LS request accepted this cycle
- o_ls_rvalid  out  1  LS completion pulse; read data valid for reads, write ack for writes
- o_ls_rdata  out  DATA_WIDTH  LS read data (0 on write completion)
- o_mem_req  out  1  memory request strobe (1 cycle)
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- o_mem_be  out  DATA_WIDTH/8  memory byte enables (all ones for IF)
- i_mem_rvalid  in  1  memory response for the outstanding request (reads and writes), arbitrary latency ≥1
- i_mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- FSM states: IDLE, WAIT_IF, WAIT_LS. Reset: state IDLE, starve_cnt 0, drop flag 0, o_if_rvalid/o_ls_rvalid 0, o_if_rdata/o_ls_rdata 0.
- Grants are issued only in IDLE. Grants are combinational from state and requests, and are mutually exclusive.
- IF is eligible when i_if_req=1 and i_if_flush=0.
- Arbitration in IDLE:
  - If starve_cnt==STARVE_LIMIT and IF is eligible, grant IF.
  - Else if i_ls_req, grant LS.
  - Else if IF is eligible, grant IF.
- Grant handling: o_mem_req = o_if_gnt | o_ls_gnt. Address, data, we and be are muxed from the granted requester, and are 0 when there is no grant. Next state is WAIT_IF or WAIT_LS.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when LS is granted while IF is eligible.
  - Clears when IF is granted, or when i_if_req=0 in IDLE.
  - Otherwise holds.
- WAIT_x: waits for i_mem_rvalid, then returns to IDLE next cycle. The response is registered, so o_x_rvalid pulses the cycle after i_mem_rvalid. Latency: grant at T, i_mem_rvalid at T+k, o_x_rvalid and IDLE at T+k+1, earliest next grant T+k+1.
- Flush:
  - i_if_flush in WAIT_IF (including the cycle of i_mem_rvalid) sets the drop flag.
  - When the response arrives with drop=1, o_if_rvalid stays 0, and drop clears on return to IDLE.
  - i_if_flush in IDLE suppresses the IF grant that cycle; LS may still be granted.
  - i_if_flush during WAIT_LS has no effect.
- Robustness: i_mem_rvalid in IDLE is ignored. Requests arriving in WAIT states are held off (gnt=0) and are not lost.
- Reset mid-transaction: return to IDLE and clear all flags. A late i_mem_rvalid after reset is ignored.

Test Plan:
- Fetch only, mem latency 1: i_if_req, addr 0x0 then 0x4 -> gnt at cycles 0 and 2. o_mem_addr 0x0, 0x4. o_if_rvalid at cycles 2 and 4 with memory data.
- Simultaneous IF+LS read, STARVE_LIMIT=4, LS requesting continuously -> LS granted 4 times, then IF granted on the 5th arbitration. starve_cnt returns to 0.
- LS write addr 0x40, wdata 0xDEADBEEF, be 0xF, latency 3 -> single o_mem_req with we=1 and correct fields. o_ls_rvalid 4 cycles after grant, o_ls_rdata 0.
- IF granted addr 0x8, i_if_flush pulsed in WAIT_IF, response 0x00000013 -> no o_if_rvalid. Next IF request addr 0x20 granted and delivers normally.
- i_if_flush with i_if_req and i_ls_req in IDLE -> LS granted, IF not granted that cycle.
- Reset asserted in WAIT_LS, then i_mem_rvalid arrives after release -> no o_ls_rvalid, state IDLE, new request granted immediately.
